// File: rtl/load_store_unit.sv
// Multicycle load/store stage between the datapath and 64-bit data memory.
// Handles lane select, sign/zero extension and read-modify-write stores.
module load_store_unit #(
    parameter int READ_LAT = 1
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        start,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [63:0] addr,
    input  logic [63:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        misaligned,
    output logic [63:0] load_data,
    output logic [63:0] mem_raddr,
    output logic [63:0] mem_waddr,
    output logic [63:0] mem_wdata,
    output logic        mem_wr,
    input  logic [63:0] mem_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        CAPTURE,
        WRITE,
        DONE
    } lsuState_t;

    lsuState_t   state;
    logic        reqStore;
    logic [2:0]  reqFunct3;
    logic [63:0] reqAddr;
    logic [63:0] reqWdata;
    logic [1:0]  latCnt;

    logic        illegal;
    logic        unaligned;
    logic        badReq;
    logic [5:0]  laneOff;
    logic [63:0] shifted;
    logic [63:0] loadExt;
    logic [63:0] sizeMask;
    logic [63:0] laneMask;
    logic [63:0] merged;

    // Request legality is judged on the live inputs, in the accepting cycle
    always_comb begin
        illegal = is_store ? funct3[2] : (funct3 == 3'b111);
        case (funct3[1:0])
            2'd0:    unaligned = 1'b0;
            2'd1:    unaligned = addr[0];
            2'd2:    unaligned = |addr[1:0];
            default: unaligned = |addr[2:0];
        endcase
        badReq = illegal | unaligned;
    end

    always_comb begin
        laneOff = {reqAddr[2:0], 3'b000};
        shifted = mem_rdata >> laneOff;
        case (reqFunct3[1:0])
            2'd0: begin
                loadExt  = {{56{shifted[7] & ~reqFunct3[2]}}, shifted[7:0]};
                sizeMask = 64'h0000_0000_0000_00FF;
            end
            2'd1: begin
                loadExt  = {{48{shifted[15] & ~reqFunct3[2]}}, shifted[15:0]};
                sizeMask = 64'h0000_0000_0000_FFFF;
            end
            2'd2: begin
                loadExt  = {{32{shifted[31] & ~reqFunct3[2]}}, shifted[31:0]};
                sizeMask = 64'h0000_0000_FFFF_FFFF;
            end
            default: begin
                loadExt  = shifted;
                sizeMask = '1;
            end
        endcase
        laneMask = sizeMask << laneOff;
        merged   = (mem_rdata & ~laneMask) | ((reqWdata << laneOff) & laneMask);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= IDLE;
            reqStore   <= 1'b0;
            reqFunct3  <= '0;
            reqAddr    <= '0;
            reqWdata   <= '0;
            latCnt     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            misaligned <= 1'b0;
            load_data  <= '0;
            mem_raddr  <= '0;
            mem_waddr  <= '0;
            mem_wdata  <= '0;
            mem_wr     <= 1'b0;
        end else begin
            done       <= 1'b0;
            misaligned <= 1'b0;
            mem_wr     <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        reqStore  <= is_store;
                        reqFunct3 <= funct3;
                        reqAddr   <= addr;
                        reqWdata  <= wdata;
                        busy      <= 1'b1;
                        if (badReq) begin
                            state      <= DONE;
                            done       <= 1'b1;
                            misaligned <= 1'b1;
                        end else if (is_store && funct3[1:0] == 2'd3) begin
                            state     <= WRITE;
                            mem_wr    <= 1'b1;
                            mem_waddr <= {addr[63:3], 3'b000};
                            mem_wdata <= wdata;
                        end else begin
                            state     <= READ;
                            mem_raddr <= {addr[63:3], 3'b000};
                            latCnt    <= 2'(READ_LAT - 1);
                        end
                    end
                end
                READ: begin
                    if (latCnt == 2'd0) begin
                        state <= CAPTURE;
                    end else begin
                        latCnt <= latCnt - 2'd1;
                    end
                end
                CAPTURE: begin
                    mem_raddr <= '0;
                    if (reqStore) begin
                        state     <= WRITE;
                        mem_wr    <= 1'b1;
                        mem_waddr <= {reqAddr[63:3], 3'b000};
                        mem_wdata <= merged;
                    end else begin
                        state     <= DONE;
                        done      <= 1'b1;
                        load_data <= loadExt;
                    end
                end
                WRITE: begin
                    mem_waddr <= '0;
                    state     <= DONE;
                    done      <= 1'b1;
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
